// File: rtl/pattern_sequencer.sv
// pattern_sequencer
// Stores a growing symbol pattern, plays it back on one-hot LEDs with
// programmable on/off timing, then checks the player's entries one symbol at
// a time in forward or reverse order.
//
// Optional feature macro: PATTERN_SEQ_ECHO_EN
//   When defined, each accepted guess during entry is echoed on led for
//   ON_CYC cycles. When undefined, led stays dark outside playback.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clr           synchronous flush: empty pattern, back to idle
//   append        push append_sym onto the pattern end (idle only)
//   play          start playback (idle, non-empty pattern only)
//   reverse       entry order select, captured when play is accepted
//   guess_valid   one-cycle strobe with the player's guess_sym
//   led           one-hot playback (and optional echo) output
//   len, full     current pattern length, length at capacity
//   busy          sequencer not idle
//   play_done     pulse: playback finished, entry starts
//   guess_ok      pulse: accepted guess matched
//   guess_err     pulse: accepted guess mismatched
//   round_done    pulse: final expected symbol matched
module pattern_sequencer #(
    parameter int NUM_SYM = 8,
    parameter int MAX_LEN = 32,
    parameter int ON_CYC  = 4,
    parameter int OFF_CYC = 2,
    localparam int SYM_W  = $clog2(NUM_SYM),
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               append,
    input  logic [SYM_W-1:0]   append_sym,
    input  logic               play,
    input  logic               reverse,
    input  logic               guess_valid,
    input  logic [SYM_W-1:0]   guess_sym,
    output logic [NUM_SYM-1:0] led,
    output logic [LEN_W-1:0]   len,
    output logic               full,
    output logic               busy,
    output logic               play_done,
    output logic               guess_ok,
    output logic               guess_err,
    output logic               round_done
);

    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHOW_ON  = 2'd1,
        S_SHOW_OFF = 2'd2,
        S_ENTRY    = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [SYM_W-1:0]   mem_r [MAX_LEN];
    logic [LEN_W-1:0]   len_r, len_s;
    logic [LEN_W-1:0]   idx_r, idx_s;
    logic [LEN_W-1:0]   cnt_r, cnt_s;
    logic [LEN_W-1:0]   len_m1_s;
    logic [AW-1:0]      ptr_r, ptr_s;
    logic [TW-1:0]      timer_r, timer_s;
    logic               rev_r, rev_s;
    logic               wr_en_s;
    logic [NUM_SYM-1:0] led_r, led_s;
    logic               busy_r, full_r;
    logic               play_done_r, play_done_s;
    logic               guess_ok_r, guess_ok_s;
    logic               guess_err_r, guess_err_s;
    logic               round_done_r, round_done_s;
`ifdef PATTERN_SEQ_ECHO_EN
    localparam int EW = $clog2(ON_CYC + 1);
    logic [EW-1:0]      echo_cnt_r, echo_cnt_s;
    logic [SYM_W-1:0]   echo_sym_r, echo_sym_s;
`endif

    // Symbols outside the alphabet light nothing.
    function automatic logic [NUM_SYM-1:0] sym_onehot(input logic [SYM_W-1:0] sym);
        logic [NUM_SYM-1:0] v;
        v = '0;
        if (int'(sym) < NUM_SYM) begin
            v[sym] = 1'b1;
        end else begin
            v = '0;
        end
        return v;
    endfunction

    assign len_m1_s = len_r - LEN_W'(1);

    // Pattern storage; contents are don't-care after reset/clr, len gates validity.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst && !clr) begin
            mem_r[len_r[AW-1:0]] <= append_sym;
        end
    end

    // State register plus datapath and registered outputs; rst and clr both empty the sequencer.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_r      <= S_IDLE;
            len_r        <= '0;
            idx_r        <= '0;
            cnt_r        <= '0;
            ptr_r        <= '0;
            timer_r      <= '0;
            rev_r        <= 1'b0;
            led_r        <= '0;
            busy_r       <= 1'b0;
            full_r       <= 1'b0;
            play_done_r  <= 1'b0;
            guess_ok_r   <= 1'b0;
            guess_err_r  <= 1'b0;
            round_done_r <= 1'b0;
`ifdef PATTERN_SEQ_ECHO_EN
            echo_cnt_r   <= '0;
            echo_sym_r   <= '0;
`endif
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            ptr_r        <= ptr_s;
            timer_r      <= timer_s;
            rev_r        <= rev_s;
            led_r        <= led_s;
            busy_r       <= (state_s != S_IDLE);
            full_r       <= (len_s == LEN_W'(MAX_LEN));
            play_done_r  <= play_done_s;
            guess_ok_r   <= guess_ok_s;
            guess_err_r  <= guess_err_s;
            round_done_r <= round_done_s;
`ifdef PATTERN_SEQ_ECHO_EN
            echo_cnt_r   <= echo_cnt_s;
            echo_sym_r   <= echo_sym_s;
`endif
        end
    end

    // Next-state and datapath decisions, including which pulse fires next cycle.
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        ptr_s        = ptr_r;
        timer_s      = timer_r;
        rev_s        = rev_r;
        wr_en_s      = 1'b0;
        play_done_s  = 1'b0;
        guess_ok_s   = 1'b0;
        guess_err_s  = 1'b0;
        round_done_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                // append wins over a simultaneous play
                if (append) begin
                    if (!full_r) begin
                        wr_en_s = 1'b1;
                        len_s   = len_r + LEN_W'(1);
                    end else begin
                        len_s   = len_r;
                    end
                end else if (play && (len_r != '0)) begin
                    rev_s   = reverse;
                    idx_s   = '0;
                    timer_s = '0;
                    state_s = S_SHOW_ON;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SHOW_ON: begin
                if (timer_r == TW'(ON_CYC - 1)) begin
                    timer_s = '0;
                    state_s = S_SHOW_OFF;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            S_SHOW_OFF: begin
                if (timer_r == TW'(OFF_CYC - 1)) begin
                    timer_s = '0;
                    if (idx_r < len_m1_s) begin
                        idx_s   = idx_r + LEN_W'(1);
                        state_s = S_SHOW_ON;
                    end else begin
                        state_s     = S_ENTRY;
                        play_done_s = 1'b1;
                        ptr_s       = rev_r ? len_m1_s[AW-1:0] : '0;
                        cnt_s       = '0;
                    end
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            S_ENTRY: begin
                if (guess_valid) begin
                    if (guess_sym == mem_r[ptr_r]) begin
                        guess_ok_s = 1'b1;
                        if (cnt_r == len_m1_s) begin
                            round_done_s = 1'b1;
                            state_s      = S_IDLE;
                        end else begin
                            cnt_s = cnt_r + LEN_W'(1);
                            ptr_s = rev_r ? (ptr_r - AW'(1)) : (ptr_r + AW'(1));
                        end
                    end else begin
                        // pattern and len are kept so the mode logic can retry
                        guess_err_s = 1'b1;
                        state_s     = S_IDLE;
                    end
                end else begin
                    state_s = S_ENTRY;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // LED value for the next cycle, derived from where the machine is heading.
    always_comb begin
        led_s = '0;
`ifdef PATTERN_SEQ_ECHO_EN
        echo_cnt_s = '0;
        echo_sym_s = echo_sym_r;
`endif
        if (state_s == S_SHOW_ON) begin
            led_s = sym_onehot(mem_r[idx_s[AW-1:0]]);
        end else if (state_s == S_ENTRY) begin
`ifdef PATTERN_SEQ_ECHO_EN
            // a fresh guess restarts the echo; leaving ENTRY cuts it
            if ((state_r == S_ENTRY) && guess_valid) begin
                echo_cnt_s = EW'(ON_CYC);
                echo_sym_s = guess_sym;
            end else if (echo_cnt_r != '0) begin
                echo_cnt_s = echo_cnt_r - EW'(1);
            end else begin
                echo_cnt_s = '0;
            end
            led_s = (echo_cnt_s != '0) ? sym_onehot(echo_sym_s) : '0;
`else
            led_s = '0;
`endif
        end else begin
            led_s = '0;
        end
    end

    assign led        = led_r;
    assign len        = len_r;
    assign full       = full_r;
    assign busy       = busy_r;
    assign play_done  = play_done_r;
    assign guess_ok   = guess_ok_r;
    assign guess_err  = guess_err_r;
    assign round_done = round_done_r;

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Parametrised successor to the game's pattern display and input handler. Stores a growing symbol pattern and plays it back on one-hot LEDs with programmable on/off timing. It then checks the player's entries symbol by symbol, in forward or reverse order. It sits between the mode FSMs (classic/time/reverse) and the LED/button I/O, and replaces whole-word shift/compare with per-symbol checking.

Parameters:
NUM_SYM, 8, number of distinct symbols; LED width. Must be >= 2. SYM_W = $clog2(NUM_SYM) is a derived localparam.
MAX_LEN, 32, maximum pattern length in symbols. LEN_W = $clog2(MAX_LEN+1) is a derived localparam.
ON_CYC, 4, clock cycles each symbol is lit during playback (>= 1).
OFF_CYC, 2, dark clock cycles after each symbol during playback (>= 1).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
clr  in  1  synchronous flush: len->0, state->IDLE
append  in  1  pulse: push append_sym onto pattern end (IDLE only)
append_sym  in  SYM_W  symbol to append
play  in  1  pulse: start playback (IDLE only)
reverse  in  1  entry-order select, sampled on accepted play
guess_valid  in  1  one-cycle strobe, player symbol present
guess_sym  in  SYM_W  player symbol
led  out  NUM_SYM  one-hot playback output
len  out  LEN_W  current pattern length
full  out  1  len == MAX_LEN
busy  out  1  state != IDLE
play_done  out  1  pulse: playback finished, entry begins
guess_ok  out  1  pulse: accepted guess matched
guess_err  out  1  pulse: accepted guess mismatched
round_done  out  1  pulse: final expected symbol matched

Behaviour:
- Reset values: state IDLE, len 0, led 0, busy 0, full 0, all pulses 0. Pattern storage contents are don't-care.
- Priority each cycle: rst > clr > state-machine actions.
- clr in any state: len 0, state IDLE, led 0, pulses 0, on the next edge.
- States: IDLE, SHOW_ON, SHOW_OFF, ENTRY.
- IDLE:
  - append with !full: mem[len] <= append_sym; len+1 next cycle.
  - append with full: ignored, len unchanged.
  - append_sym >= NUM_SYM: stored as given; playback then drives led 0 for that slot.
  - play with len > 0: latch reverse, idx <= 0, timer <= 0, go SHOW_ON.
  - play with len == 0: ignored.
  - append and play in the same cycle: append applied, play ignored.
- SHOW_ON: led = one-hot(mem[idx]) for exactly ON_CYC cycles, then SHOW_OFF.
- SHOW_OFF: led = 0 for exactly OFF_CYC cycles.
  - If idx < len-1: idx+1, back to SHOW_ON.
  - Else: play_done pulses for one cycle coincident with entry into ENTRY; ptr <= (rev ? len-1 : 0), cnt <= 0.
- Playback timing: led first asserts the cycle after play is accepted. Total playback = len*(ON_CYC+OFF_CYC) cycles.
- ENTRY, on guess_valid, compare guess_sym to mem[ptr]:
  - Match, not last (cnt < len-1): guess_ok pulses the next cycle; ptr steps ±1; cnt+1.
  - Match, last: guess_ok and round_done both pulse the next cycle; go IDLE.
  - Mismatch: guess_err pulses the next cycle; go IDLE. Pattern and len are retained so the mode FSM decides between retry and clr.
- guess_valid outside ENTRY is ignored. append and play are ignored while busy.
- Playback order is always forward. Entry order is forward when the latched reverse = 0 and last-to-first when reverse = 1.
- Outputs are registered; led changes only on clk edges.

Optional Feature:
PATTERN_SEQ_ECHO_EN
- Defined: during ENTRY each accepted guess drives led = one-hot(guess_sym) for ON_CYC cycles, starting the cycle after guess_valid.
  - A new guess_valid restarts the echo with the new symbol.
  - The echo is cut to 0 on leaving ENTRY.
- Undefined: led is 0 throughout ENTRY and IDLE.

Test Plan:
1. Reset, then append 3,5,1; play with reverse=0 and ON_CYC=4/OFF_CYC=2.
   -> led = 0x08 x4, 0 x2, 0x20 x4, 0 x2, 0x02 x4, 0 x2; play_done on cycle 18 after play; len = 3.
2. Continuing from scenario 1, guesses 3,5,1.
   -> guess_ok pulses 3 times, round_done with the third, busy 0 afterwards.
3. Same pattern, play with reverse=1, guesses 1,5,3.
   -> round_done. Separately, guesses 3 then anything -> guess_err on the first guess, state IDLE, len still 3.
4. Append 33 times with MAX_LEN=32.
   -> full = 1 after the 32nd, 33rd ignored, len = 32. play with len=0 after clr -> busy stays 0.
5. clr asserted mid-SHOW_ON; later rst asserted mid-ENTRY.
   -> next cycle led = 0, busy = 0, len = 0, no pulses.
6. Hazards: append+play in the same IDLE cycle -> len+1, busy 0; guess_valid during SHOW_ON -> no guess_ok or guess_err. With PATTERN_SEQ_ECHO_EN, guess 5 in ENTRY -> led = 0x20 for 4 cycles.
